// File: rtl/st_pushpop_seq.sv
// rtl/st_pushpop_seq.sv - Thumb PUSH/POP multi-cycle register-list sequencer
//
// Expands a 9-bit register list into one data-memory access per cycle.
// Ports:
//   clk, resetn (sync, active-high)       clock and reset
//   start_push, start_pop, rlist, sp_in    request, captured only in IDLE
//   lr_in                                  LR value stored for the bit-8 push entry
//   rf_raddr / rf_rdata                    register-file read port (combinational)
//   rf_wr / rf_waddr / rf_wdata            register-file write port
//   dmem_addr/wdata/we/re, dmem_rdata      data memory (load data one cycle after re)
//   pc_wr / pc_out, sp_wr / sp_out         PC load (pop PC) and final SP update
//   busy, done                             pipeline stall and completion pulse
module st_pushpop_seq #(
    parameter int NREG = 8,
    parameter int AW   = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_push,
    input  logic              start_pop,
    input  logic [NREG:0]     rlist,
    input  logic [AW-1:0]     sp_in,
    input  logic [AW-1:0]     lr_in,
    output logic [2:0]        rf_raddr,
    input  logic [31:0]       rf_rdata,
    output logic [AW-1:0]     dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [31:0]       dmem_rdata,
    output logic              rf_wr,
    output logic [2:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              pc_wr,
    output logic [AW-1:0]     pc_out,
    output logic              sp_wr,
    output logic [AW-1:0]     sp_out,
    output logic              busy,
    output logic              done
);

    localparam int LW = NREG + 1;
    localparam int CW = $clog2(LW);

    typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_WB, S_FIN} state_t;

    state_t        state, state_n;
    logic [NREG:0] mask_q;      // registers still to transfer
    logic [AW-1:0] addr_q;      // address of the current access
    logic [AW-1:0] sp_fin_q;    // SP value written in FIN
    logic          wb_valid_q;  // a pop load issued last cycle needs writeback
    logic          wb_pc_q;     // that load was the PC entry
    logic [2:0]    wb_idx_q;

    logic [AW-1:0] n_words;
    logic [AW-1:0] n_bytes;
    logic [CW-1:0] cur_idx;
    logic          cur_hi;
    logic [NREG:0] mask_rest;
    logic          start_any;

    assign start_any = start_push | start_pop;

    always_comb begin
        n_words = '0;
        for (int i = 0; i < LW; i++) begin
            n_words = n_words + AW'(rlist[i]);
        end
        n_bytes = n_words << 2;
    end

    // Lowest set bit of the remaining mask gives ascending register order.
    always_comb begin
        cur_idx = '0;
        for (int i = LW - 1; i >= 0; i--) begin
            if (mask_q[i]) cur_idx = CW'(i);
        end
    end

    assign cur_hi    = (cur_idx == CW'(NREG));
    assign mask_rest = mask_q & (mask_q - 1'b1);

    always_ff @(posedge clk) begin
        if (resetn) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            mask_q     <= '0;
            addr_q     <= '0;
            sp_fin_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_pc_q    <= 1'b0;
            wb_idx_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_any) begin
                        mask_q     <= rlist;
                        wb_valid_q <= 1'b0;
                        if (start_push) begin
                            addr_q   <= sp_in - n_bytes;
                            sp_fin_q <= sp_in - n_bytes;
                        end else begin
                            addr_q   <= sp_in;
                            sp_fin_q <= sp_in + n_bytes;
                        end
                    end
                end
                S_PUSH: begin
                    mask_q <= mask_rest;
                    addr_q <= addr_q + AW'(4);
                end
                S_POP: begin
                    mask_q     <= mask_rest;
                    addr_q     <= addr_q + AW'(4);
                    wb_valid_q <= 1'b1;
                    wb_pc_q    <= cur_hi;
                    wb_idx_q   <= cur_idx[2:0];
                end
                S_WB:    wb_valid_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        rf_raddr   = '0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        rf_wr      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        pc_wr      = 1'b0;
        pc_out     = '0;
        sp_wr      = 1'b0;
        sp_out     = '0;
        done       = 1'b0;
        busy       = (state != S_IDLE);

        // Pop writeback of the previous cycle's load, overlapping the next load.
        if ((state == S_POP || state == S_WB) && wb_valid_q) begin
            if (wb_pc_q) begin
                pc_wr  = 1'b1;
                pc_out = dmem_rdata[AW-1:0];
            end else begin
                rf_wr    = 1'b1;
                rf_waddr = wb_idx_q;
                rf_wdata = dmem_rdata;
            end
        end

        case (state)
            S_IDLE: begin
                if (start_any) begin
                    if (rlist == '0)     state_n = S_FIN;
                    else if (start_push) state_n = S_PUSH;
                    else                 state_n = S_POP;
                end
            end
            S_PUSH: begin
                dmem_we   = 1'b1;
                dmem_addr = addr_q;
                if (cur_hi) begin
                    dmem_wdata = {{(32 - AW){1'b0}}, lr_in};
                end else begin
                    rf_raddr   = cur_idx[2:0];
                    dmem_wdata = rf_rdata;
                end
                if (mask_rest == '0) state_n = S_FIN;
            end
            S_POP: begin
                dmem_re   = 1'b1;
                dmem_addr = addr_q;
                if (mask_rest == '0) state_n = S_WB;
            end
            S_WB:    state_n = S_FIN;
            S_FIN: begin
                sp_wr   = 1'b1;
                sp_out  = sp_fin_q;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_st_pushpop_seq.sv
// tb/tb_st_pushpop_seq.sv - directed self-checking bench for st_pushpop_seq
module tb_st_pushpop_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_push, start_pop;
    logic [8:0]  rlist;
    logic [15:0] sp_in, lr_in;
    logic [2:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we, dmem_re;
    logic [31:0] dmem_rdata;
    logic        rf_wr;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pc_wr;
    logic [15:0] pc_out;
    logic        sp_wr;
    logic [15:0] sp_out;
    logic        busy, done;

    st_pushpop_seq dut (
        .clk(clk), .resetn(resetn), .start_push(start_push), .start_pop(start_pop),
        .rlist(rlist), .sp_in(sp_in), .lr_in(lr_in), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata),
        .rf_wr(rf_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_wr(pc_wr),
        .pc_out(pc_out), .sp_wr(sp_wr), .sp_out(sp_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory and register-file models
    logic [31:0] mem [0:65535];
    logic [31:0] rf  [0:7];
    logic [31:0] rd_next;
    assign rf_rdata = rf[rf_raddr];

    int          cyc = 0;
    logic [15:0] st_addr [$];
    logic [31:0] st_data [$];
    int re_cnt, rfw_cnt, pc_cnt, sp_cnt, done_cnt, done_cyc, start_cyc;
    logic [15:0] pc_val, sp_val;

    always @(posedge clk) begin
        cyc++;
        dmem_rdata <= rd_next;
    end

    // Outputs are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dmem_we) begin
            st_addr.push_back(dmem_addr);
            st_data.push_back(dmem_wdata);
            mem[dmem_addr] = dmem_wdata;
        end
        rd_next = dmem_re ? mem[dmem_addr] : 32'h0;
        if (dmem_re) re_cnt++;
        if (rf_wr) begin rf[rf_waddr] = rf_wdata; rfw_cnt++; end
        if (pc_wr) begin pc_val = pc_out; pc_cnt++; end
        if (sp_wr) begin sp_val = sp_out; sp_cnt++; end
        if (done)  begin done_cyc = cyc; done_cnt++; end
    end

    task automatic clear_logs();
        st_addr.delete();
        st_data.delete();
        re_cnt = 0; rfw_cnt = 0; pc_cnt = 0; sp_cnt = 0; done_cnt = 0;
        done_cyc = -1; pc_val = '0; sp_val = '0;
    endtask

    task automatic start_req(input logic push, input logic pop, input logic [8:0] rl,
                             input logic [15:0] sp);
        clear_logs();
        @(posedge clk); #2;
        start_push = push; start_pop = pop; rlist = rl; sp_in = sp;
        start_cyc = cyc;
        @(posedge clk); #2;
        start_push = 1'b0; start_pop = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt != 0) break;
            @(posedge clk); #2;
        end
        check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_strobes"}, {25'b0, busy, done, dmem_we, dmem_re, rf_wr, pc_wr, sp_wr}, 32'h0);
        check({tag, "_addrs"}, {13'b0, rf_raddr, dmem_addr | sp_out | pc_out}, 32'h0);
        check({tag, "_data"}, {29'b0, rf_waddr} | dmem_wdata | rf_wdata, 32'h0);
    endtask

    initial begin
        resetn = 1'b1; start_push = 1'b0; start_pop = 1'b0;
        rlist = '0; sp_in = '0; lr_in = '0; rd_next = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #4;
        check_idle_outputs("reset");

        // Push r0, r2 without LR
        rf[0] = 32'h11; rf[2] = 32'h22;
        start_req(1'b1, 1'b0, 9'h005, 16'h0100);
        wait_done("push1");
        check("push1_nstores", 32'(st_addr.size()), 32'd2);
        if (st_addr.size() == 2) begin
            check("push1_a0", 32'(st_addr[0]), 32'h00F8);
            check("push1_d0", st_data[0], 32'h11);
            check("push1_a1", 32'(st_addr[1]), 32'h00FC);
            check("push1_d1", st_data[1], 32'h22);
        end
        check("push1_sp", 32'(sp_val), 32'h00F8);
        check("push1_lat", 32'(done_cyc - start_cyc), 32'd3);
        check("push1_no_load", 32'(re_cnt), 32'd0);

        // Pop r1 and PC
        mem[16'h00F8] = 32'hAB; mem[16'h00FC] = 32'h0040; rf[1] = 32'h0;
        start_req(1'b0, 1'b1, 9'h102, 16'h00F8);
        wait_done("pop1");
        check("pop1_r1", rf[1], 32'hAB);
        check("pop1_rfw_cnt", 32'(rfw_cnt), 32'd1);
        check("pop1_pc_cnt", 32'(pc_cnt), 32'd1);
        check("pop1_pc", 32'(pc_val), 32'h0040);
        check("pop1_sp", 32'(sp_val), 32'h0100);
        check("pop1_lat", 32'(done_cyc - start_cyc), 32'd4);
        check("pop1_no_store", 32'(st_addr.size()), 32'd0);

        // Full list with LR
        for (int i = 0; i < 8; i++) rf[i] = 32'h100 + 32'(i);
        lr_in = 16'h1234;
        start_req(1'b1, 1'b0, 9'h1FF, 16'h0200);
        wait_done("pushfull");
        check("pushfull_nstores", 32'(st_addr.size()), 32'd9);
        if (st_addr.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("pushfull_a%0d", k), 32'(st_addr[k]), 32'h01DC + 32'(4 * k));
                check($sformatf("pushfull_d%0d", k), st_data[k],
                      (k < 8) ? 32'h100 + 32'(k) : 32'h00001234);
            end
        end
        check("pushfull_sp", 32'(sp_val), 32'h01DC);
        check("pushfull_lat", 32'(done_cyc - start_cyc), 32'd10);

        // Empty list with both starts
        start_req(1'b1, 1'b1, 9'h000, 16'h0300);
        wait_done("empty");
        check("empty_mem", 32'(st_addr.size() + re_cnt), 32'd0);
        check("empty_sp", 32'(sp_val), 32'h0300);
        check("empty_lat", 32'(done_cyc - start_cyc), 32'd1);

        // Reset mid-pop
        start_req(1'b0, 1'b1, 9'h0FF, 16'h0400);
        @(posedge clk); #2 resetn = 1'b1;
        @(posedge clk); #2 resetn = 1'b0;
        #4;
        check_idle_outputs("midreset");
        repeat (10) @(posedge clk);
        check("midreset_no_spwr", 32'(sp_cnt), 32'd0);
        check("midreset_no_done", 32'(done_cnt), 32'd0);

        // Start requests while busy are ignored
        rf[0] = 32'hA0; rf[1] = 32'hA1;
        start_req(1'b1, 1'b0, 9'h003, 16'h0500);
        start_push = 1'b1; start_pop = 1'b1; rlist = 9'h0F0; sp_in = 16'h0900;
        @(posedge clk); #2;
        start_push = 1'b0; start_pop = 1'b0;
        wait_done("guard");
        repeat (6) @(posedge clk);
        check("guard_done_cnt", 32'(done_cnt), 32'd1);
        check("guard_nstores", 32'(st_addr.size()), 32'd2);
        if (st_addr.size() == 2) begin
            check("guard_a0", 32'(st_addr[0]), 32'h04F8);
            check("guard_d1", st_data[1], 32'hA1);
        end
        check("guard_sp", 32'(sp_val), 32'h04F8);

        // Address wrap-around
        start_req(1'b1, 1'b0, 9'h003, 16'h0004);
        wait_done("wrap");
        check("wrap_nstores", 32'(st_addr.size()), 32'd2);
        if (st_addr.size() == 2) begin
            check("wrap_a0", 32'(st_addr[0]), 32'hFFFC);
            check("wrap_a1", 32'(st_addr[1]), 32'h0000);
        end
        check("wrap_sp", 32'(sp_val), 32'hFFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/st_pushpop_seq.md
Name: st_pushpop_seq

Overview:
- Multi-cycle sequencer for Thumb PUSH {rlist[,LR]} and POP {rlist[,PC]} in the stack unit of dsd_processor.
- Expands the 9-bit register list into one data-memory access per register, one per cycle.
- Drives the register-file read and write ports, PC write and SP update, and holds busy high to stall the pipeline while a transfer is in progress.

Parameters:
- NREG, 8: number of low registers in the register list (r0..r7); bit NREG is LR for push and PC for pop.
- AW, 16: address, SP and PC width.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- resetn  in  1  synchronous, active-high reset; 1 resets the block on the rising clock edge.
- start_push  in  1  one-cycle request for a PUSH; sampled only in IDLE.
- start_pop  in  1  one-cycle request for a POP; sampled only in IDLE.
- rlist  in  9  register list; bit i = ri, bit 8 = LR (push) or PC (pop); captured with the start request.
- sp_in  in  16  current SP; captured with the start request.
- lr_in  in  16  current LR value.
- rf_raddr  out  3  register-file read address.
- rf_rdata  in  32  register-file read data, combinational same-cycle read.
- dmem_addr  out  16  data-memory address.
- dmem_wdata  out  32  data-memory write data.
- dmem_we  out  1  data-memory store strobe.
- dmem_re  out  1  data-memory load strobe.
- dmem_rdata  in  32  load data, valid exactly one cycle after dmem_re.
- rf_wr  out  1  register-file write enable.
- rf_waddr  out  3  register-file write address.
- rf_wdata  out  32  register-file write data.
- pc_wr  out  1  PC write strobe.
- pc_out  out  16  new PC value.
- sp_wr  out  1  SP write strobe.
- sp_out  out  16  new SP value.
- busy  out  1  pipeline stall.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, PUSH, POP, WB, FIN.
- Reset (resetn=1 at a clock edge): state returns to IDLE. All outputs go to 0: every strobe (dmem_we, dmem_re, rf_wr, pc_wr, sp_wr, done), busy, and every address/data output.
- Reset mid-transfer: the transfer is aborted, no sp_wr is issued, and the block is IDLE on the next cycle.
- Start capture in IDLE: on start_push or start_pop, capture rlist, sp_in and N = popcount(rlist).
  - Capture base = sp_in − 4N for push, or sp_in for pop.
  - If both starts are high, push wins and pop is dropped.
  - Starts outside IDLE are ignored.
- Empty list (N=0): go IDLE→FIN; sp_out = sp_in.
- Output timing: strobes and addresses are decoded from registered state only; there is no combinational path from start_* to any output. busy = 1 in every state except IDLE.
- Register order: strictly ascending (r0..r7, then bit 8). The k-th selected register (k = 0..N−1) uses address base + 4k, so the lowest register sits at the lowest address.
- PUSH state, one store per cycle for N cycles:
  - Per cycle: dmem_we=1, dmem_addr = base+4k, rf_raddr = register index.
  - dmem_wdata = rf_rdata, or {16'b0, lr_in} for the bit-8 entry.
  - After the N-th store go to FIN.
- POP state, one load per cycle for N cycles: dmem_re=1, dmem_addr = base+4k.
  - Writeback lags its load by one cycle and overlaps the next load.
  - Low registers: rf_wr=1, rf_waddr = the previous cycle's register, rf_wdata = dmem_rdata.
  - Bit-8 entry: pc_wr=1, pc_out = dmem_rdata[15:0], rf_wr=0.
  - After the last load go to WB.
- WB state: final writeback only, no memory access; then FIN.
- FIN state (one cycle): sp_wr=1, done=1.
  - sp_out = sp_in − 4N for push, sp_in + 4N for pop.
  - Next state is IDLE; a new start is accepted in the cycle after FIN.
- Latency from start to done: push takes N+1 cycles; pop takes N+2 cycles (N≥1); an empty list takes 1 cycle.
- Arithmetic: all address and SP arithmetic is modulo 2^16; wrap-around is allowed and is not flagged.

Test Plan:
- Push without LR: start_push, rlist=0x005 (r0, r2), sp_in=0x0100, r0=0x11, r2=0x22 → stores 0x11@0x00F8 then 0x22@0x00FC; FIN: sp_out=0x00F8, done 3 cycles after start.
- Pop with PC: start_pop, rlist=0x102 (r1, PC), sp_in=0x00F8, mem[0x00F8]=0xAB, mem[0x00FC]=0x0040 → r1=0xAB, pc_wr with pc_out=0x0040, sp_out=0x0100, done 4 cycles after start.
- Push with LR, full list: rlist=0x1FF, sp_in=0x0200, lr_in=0x1234 → 9 stores at 0x01DC..0x01FC, with LR at 0x01FC stored as 0x00001234; sp_out=0x01DC.
- Empty list and simultaneous starts: start_push=start_pop=1, rlist=0 → no memory access, push path taken, sp_out=sp_in, done 1 cycle after start.
- Reset and busy guard: start_pop with rlist=0x0FF, then resetn=1 on the 3rd cycle → no sp_wr, all outputs 0, IDLE; separately, a start_push issued while busy has no effect.
- Wrap-around: push with rlist=0x003, sp_in=0x0004 → stores at 0xFFFC and 0x0000; sp_out=0xFFFC.
